spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 24 ++
 rtl/spi_slave.sv | 121 ++++++++++++
 tb/tb_spi_slave.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// Byte-side handshake between spi_slave and its local consumer/producer.
//   tx_data/tx_load -> transmit buffer write, tx_full <- buffer occupied
//   rx_data/rx_valid <- last received byte, rx_ack -> consumer has read it
//   overrun/underrun <- sticky error flags
interface spi_slave_if;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       overrun;
  logic       underrun;

  modport slave (
    input  tx_data, tx_load, rx_ack,
    output tx_full, rx_data, rx_valid, overrun, underrun
  );

  modport master (
    output tx_data, tx_load, rx_ack,
    input  tx_full, rx_data, rx_valid, overrun, underrun
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: receives LSB-first bytes on mosi and sends MSB-first bytes on miso.
// A one-deep transmit buffer feeds the shifter; IDLE_BYTE is sent when it is empty.
// Ports:
//   sclk  - mode-normalised SPI clock (sample on rise, shift on fall)
//   reset - asynchronous, active-high
//   csbar - active-low select; mosi - serial in; miso - serial out, high-Z when deselected
//   bus   - byte-side handshake (spi_slave_if.slave)
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        csbar,
  input  logic        mosi,
  output wire         miso,
  spi_slave_if.slave  bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic              overrun_q;

  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic              tx_full_q;
  logic              src_idle_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic              underrun_q;
  logic              miso_q;

  logic [DATA_W-1:0] rx_byte_c;
  logic              complete_c;
  logic              reload_c;
  logic              load_ok_c;

  // Byte-boundary and reload decisions for this rising edge
  always_comb begin
    rx_byte_c  = {mosi, rx_shift_q[DATA_W-1:1]};
    complete_c = !csbar && (rx_cnt_q == LAST_BIT);
    // While deselected, refresh the shifter only if it holds stale idle data
    // or a newer byte is waiting; a buffered byte already loaded is kept.
    reload_c   = csbar ? (tx_full_q || src_idle_q) : (tx_cnt_q == LAST_BIT);
    load_ok_c  = bus.tx_load && !tx_full_q;
  end

  // Receive path
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_cnt_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (csbar) begin
        rx_cnt_q <= '0;
      end else begin
        rx_shift_q <= rx_byte_c;
        rx_cnt_q   <= complete_c ? '0 : CNT_W'(rx_cnt_q + 1'b1);
      end
      if (complete_c) begin
        rx_data_q  <= rx_byte_c;
        rx_valid_q <= 1'b1;
        if (rx_valid_q && !bus.rx_ack) overrun_q <= 1'b1;
      end else if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // Transmit buffer, shifter and bit counter
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      tx_cnt_q   <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      tx_shift_q <= IDLE_BYTE;
      src_idle_q <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      tx_cnt_q <= (csbar || tx_cnt_q == LAST_BIT) ? '0 : CNT_W'(tx_cnt_q + 1'b1);
      if (reload_c) begin
        if (tx_full_q) begin
          tx_shift_q <= tx_buf_q;
          src_idle_q <= 1'b0;
        end else begin
          tx_shift_q <= IDLE_BYTE;
          src_idle_q <= 1'b1;
        end
      end
      // load_ok_c implies the buffer is empty, so it never races the consume
      if (load_ok_c) begin
        tx_buf_q  <= bus.tx_data;
        tx_full_q <= 1'b1;
      end else if (reload_c && tx_full_q) begin
        tx_full_q <= 1'b0;
      end
      if (!csbar && tx_cnt_q == '0 && src_idle_q) underrun_q <= 1'b1;
    end
  end

  // Output bit is launched on the falling edge, half a cycle before the master samples
  always_ff @(negedge sclk or posedge reset) begin
    if (reset) miso_q <= 1'b0;
    else       miso_q <= tx_shift_q[LAST_BIT - tx_cnt_q];
  end

  assign miso         = csbar ? 1'bz : miso_q;
  assign bus.tx_full  = tx_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus queues expected miso bits and
// received bytes; a monitor pops and compares them as the DUT presents them.
module tb_spi_slave;

  logic sclk;
  logic reset;
  logic csbar;
  logic mosi;
  wire  miso;

  spi_slave_if bus ();

  spi_slave #(.IDLE_BYTE(8'hA5)) dut (
    .sclk  (sclk),
    .reset (reset),
    .csbar (csbar),
    .mosi  (mosi),
    .miso  (miso),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic       exp_miso[$];
  logic [7:0] exp_rx[$];

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the falling edge
  task automatic step();
    @(negedge sclk);
    #1;
  endtask

  task automatic partial(input logic [7:0] mo, input logic [7:0] mi, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      csbar = 1'b0;
      mosi  = mo[i];
      exp_miso.push_back(mi[7-i]);
      step();
    end
  endtask

  task automatic send_byte(input logic [7:0] mo, input logic [7:0] mi, input bit ack_last);
    for (int i = 0; i < 8; i++) begin
      csbar = 1'b0;
      mosi  = mo[i];
      exp_miso.push_back(mi[7-i]);
      if (i == 7) begin
        exp_rx.push_back(mo);
        if (ack_last) bus.rx_ack = 1'b1;
      end
      step();
      bus.rx_ack = 1'b0;
    end
  endtask

  task automatic deselect(input int n);
    csbar = 1'b1;
    mosi  = 1'b0;
    repeat (n) step();
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    step();
    bus.rx_ack = 1'b0;
  endtask

  // Monitor: master samples miso on the rising edge; a new rx byte is a
  // rising rx_valid or a changed rx_data while valid.
  initial begin
    logic       pv;
    logic [7:0] pd;
    logic       eb;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(posedge sclk);
      #1;
      if (!reset && !csbar) begin
        if (exp_miso.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL miso_extra: got %b expected no bit (t=%0t)", miso, $time);
        end else begin
          eb = exp_miso.pop_front();
          check1("miso_bit", miso, eb);
        end
      end
      if (bus.rx_valid && (!pv || bus.rx_data != pd)) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_extra: got %h expected no byte (t=%0t)", bus.rx_data, $time);
        end else begin
          check8("rx_byte", bus.rx_data, exp_rx.pop_front());
        end
      end
      pv = bus.rx_valid;
      pd = bus.rx_data;
    end
  end

  initial begin
    reset       = 1'b1;
    csbar       = 1'b1;
    mosi        = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    bus.rx_ack  = 1'b0;
    step();
    step();
    check1("reset_tx_full", bus.tx_full, 1'b0);
    check1("reset_rx_valid", bus.rx_valid, 1'b0);
    check8("reset_rx_data", bus.rx_data, 8'h00);
    check1("reset_overrun", bus.overrun, 1'b0);
    check1("reset_underrun", bus.underrun, 1'b0);
    reset = 1'b0;
    step();
    step();

    // Load and exchange: C3 out, 5A in
    bus.tx_data = 8'hC3;
    bus.tx_load = 1'b1;
    step();
    bus.tx_load = 1'b0;
    check1("load_tx_full", bus.tx_full, 1'b1);
    step();
    send_byte(8'h5A, 8'hC3, 1'b0);
    deselect(1);
    check1("xchg_rx_valid", bus.rx_valid, 1'b1);
    check8("xchg_rx_data", bus.rx_data, 8'h5A);
    check1("xchg_underrun", bus.underrun, 1'b0);
    check1("xchg_tx_full", bus.tx_full, 1'b0);
    ack();
    check1("ack_rx_valid", bus.rx_valid, 1'b0);

    // No load: idle byte goes out, underrun flagged
    send_byte(8'h3C, 8'hA5, 1'b0);
    deselect(1);
    check1("noload_underrun", bus.underrun, 1'b1);
    ack();

    // Overrun: two bytes without ack
    send_byte(8'h11, 8'hA5, 1'b0);
    send_byte(8'h22, 8'hA5, 1'b0);
    deselect(1);
    check1("ovr_overrun", bus.overrun, 1'b1);
    check8("ovr_rx_data", bus.rx_data, 8'h22);
    reset = 1'b1;
    step();
    check1("ovr_reset_clears", bus.overrun, 1'b0);
    reset = 1'b0;
    step();

    // Same two bytes, ack on the completion edge of the second
    send_byte(8'h11, 8'hA5, 1'b0);
    send_byte(8'h22, 8'hA5, 1'b1);
    deselect(1);
    check1("ackedge_overrun", bus.overrun, 1'b0);
    check1("ackedge_rx_valid", bus.rx_valid, 1'b1);
    check8("ackedge_rx_data", bus.rx_data, 8'h22);
    ack();

    // Abort after 3 bits, then a full 81
    partial(8'hFF, 8'hA5, 0, 3);
    deselect(2);
    send_byte(8'h81, 8'hA5, 1'b0);
    deselect(1);
    check8("abort_rx_data", bus.rx_data, 8'h81);
    ack();

    // Buffer rules: second load while full is dropped
    bus.tx_data = 8'h0F;
    bus.tx_load = 1'b1;
    step();
    check1("buf_full_after_load", bus.tx_full, 1'b1);
    bus.tx_data = 8'hF0;
    step();
    bus.tx_load = 1'b0;
    send_byte(8'h96, 8'h0F, 1'b0);
    check1("buf_full_after_frame", bus.tx_full, 1'b0);
    deselect(1);
    ack();
    send_byte(8'h69, 8'hA5, 1'b0);
    deselect(1);
    check8("buf_rx_data", bus.rx_data, 8'h69);

    // Reset mid-frame after 4 bits, with a byte buffered and rx unread
    bus.tx_data = 8'h3C;
    bus.tx_load = 1'b1;
    partial(8'h0D, 8'hA5, 0, 1);
    bus.tx_load = 1'b0;
    partial(8'h0D, 8'hA5, 1, 3);
    check1("midrst_pre_tx_full", bus.tx_full, 1'b1);
    reset = 1'b1;
    csbar = 1'b1;
    mosi  = 1'b0;
    #2;
    check1("midrst_tx_full", bus.tx_full, 1'b0);
    check1("midrst_rx_valid", bus.rx_valid, 1'b0);
    check8("midrst_rx_data", bus.rx_data, 8'h00);
    check1("midrst_overrun", bus.overrun, 1'b0);
    check1("midrst_underrun", bus.underrun, 1'b0);
    step();
    reset = 1'b0;
    step();
    send_byte(8'hE7, 8'hA5, 1'b0);
    deselect(1);
    check8("postrst_rx_data", bus.rx_data, 8'hE7);
    check1("postrst_rx_valid", bus.rx_valid, 1'b1);

    deselect(3);
    check8("miso_queue_left", 8'(exp_miso.size()), 8'd0);
    check8("rx_queue_left", 8'(exp_rx.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
